// File: rtl/half_divisor_prog.sv
// Runtime-programmable clock divider: clk/N or clk/(N+0.5), with enable gating,
// ratio changes deferred to the period boundary, and illegal-divisor flagging.
module half_divisor_prog #(
    parameter int CNT_W    = 8,
    parameter int RST_DIV  = 3,
    parameter bit RST_HALF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_int,
    input  logic             div_half,
    input  logic             cfg_load,
    output logic             clk_out,
    output logic             active,
    output logic             cfg_err
);
    localparam int CW = CNT_W + 1;

    logic [CW-1:0]    cnt, cnt_n;
    logic             active_n;
    logic [CNT_W-1:0] cfg_div, cfg_div_n;
    logic             cfg_half, cfg_half_n;
    logic             pend_v, pend_v_n;
    logic [CNT_W-1:0] pend_div, pend_div_n;
    logic             pend_half, pend_half_n;
    logic             load_ok;
    logic             wrap;
    logic             rise_q, rise_n;
    logic             fall_q, fall_n;
    logic [CW-1:0]    cur_div, cur_h;

    // Last counter value of one full pattern: N-1, or 2N in half mode.
    function automatic logic [CW-1:0] last_of(input logic [CNT_W-1:0] d, input logic h);
        if (h) return {d, 1'b0};
        else   return {1'b0, d} - CW'(1);
    endfunction

    // Pulse length in whole clk cycles.
    function automatic logic [CW-1:0] high_of(input logic [CNT_W-1:0] d, input logic h);
        if (h) return ({1'b0, d} + CW'(1)) >> 1;
        else   return {1'b0, d} >> 1;
    endfunction

    assign load_ok = cfg_load && (div_int >= CNT_W'(2));
    assign wrap    = active && (cnt == last_of(cfg_div, cfg_half));
    assign cur_div = {1'b0, cfg_div};
    assign cur_h   = high_of(cfg_div, cfg_half);

    always_comb begin
        cnt_n       = cnt + CW'(1);
        active_n    = active;
        cfg_div_n   = cfg_div;
        cfg_half_n  = cfg_half;
        pend_v_n    = pend_v;
        pend_div_n  = pend_div;
        pend_half_n = pend_half;
        if (!active) begin
            // Stopped: a legal load (or leftover pending) takes effect at once.
            cnt_n    = '0;
            active_n = en;
            pend_v_n = 1'b0;
            if (load_ok) begin
                cfg_div_n  = div_int;
                cfg_half_n = div_half;
            end else if (pend_v) begin
                cfg_div_n  = pend_div;
                cfg_half_n = pend_half;
            end
        end else if (wrap) begin
            // A load presented in the wrap cycle waits for the following wrap.
            cnt_n    = '0;
            active_n = en;
            if (pend_v) begin
                cfg_div_n  = pend_div;
                cfg_half_n = pend_half;
            end
            pend_v_n    = load_ok;
            pend_div_n  = div_int;
            pend_half_n = div_half;
        end else if (load_ok) begin
            pend_v_n    = 1'b1;
            pend_div_n  = div_int;
            pend_half_n = div_half;
        end
        rise_n = active_n && (cnt_n < high_of(cfg_div_n, cfg_half_n));
    end

    // Half-cycle flop: odd-N extension of pulse A, or pulse B in half mode.
    always_comb begin
        fall_n = 1'b0;
        if (active) begin
            if (cfg_half) fall_n = (cnt >= cur_div) && (cnt < cur_div + cur_h);
            else          fall_n = cfg_div[0] && (cnt == cur_h - CW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            active    <= 1'b0;
            cfg_div   <= CNT_W'(RST_DIV);
            cfg_half  <= RST_HALF;
            pend_v    <= 1'b0;
            pend_div  <= '0;
            pend_half <= 1'b0;
            cfg_err   <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            active    <= active_n;
            cfg_div   <= cfg_div_n;
            cfg_half  <= cfg_half_n;
            pend_v    <= pend_v_n;
            pend_div  <= pend_div_n;
            pend_half <= pend_half_n;
            cfg_err   <= cfg_load && (div_int < CNT_W'(2));
            rise_q    <= rise_n;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) fall_q <= 1'b0;
        else     fall_q <= fall_n;
    end

    assign clk_out = rise_q | fall_q;

endmodule

// File: tb/tb_half_divisor_prog.sv
// Directed bench for half_divisor_prog: half-cycle sampled waveform patterns
// from a vector table plus hand-written reconfigure/stop/reset sequences.
module tb_half_divisor_prog;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_int;
    logic             div_half;
    logic             cfg_load;
    logic             clk_out;
    logic             active;
    logic             cfg_err;

    int n_vec = 0;
    int n_bad = 0;

    half_divisor_prog #(.CNT_W(CNT_W), .RST_DIV(3), .RST_HALF(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_int  (div_int),
        .div_half (div_half),
        .cfg_load (cfg_load),
        .clk_out  (clk_out),
        .active   (active),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Patterns: one bit per half clk cycle, first-sampled bit is the MSB of len.
    typedef struct {
        logic [CNT_W-1:0] n;
        logic             half;
        logic [31:0]      pat;
        int               len;
        string            name;
    } vec_t;

    localparam logic [31:0] P_3H = 32'b11110001111000;
    localparam logic [31:0] P_4  = 32'b11110000;
    localparam logic [31:0] P_5  = 32'b1111100000;
    localparam logic [31:0] P_6H = 32'b11111100000001111110000000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples ncyc clk cycles starting at the current cycle (caller sits at posedge+1).
    task automatic check_wave(input logic [31:0] pat, input int len, input int start,
                              input int ncyc, input logic exp_act, input string name);
        int   bad_at;
        int   k;
        logic e;
        logic got;
        logic act_bad;
        bad_at  = -1;
        got     = 1'b0;
        e       = 1'b0;
        act_bad = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (s == 1) begin
                    @(negedge clk);
                    #1;
                end
                k = (start + 2 * c + s) % len;
                if (bad_at < 0 && clk_out !== pat[len-1-k]) begin
                    bad_at = 2 * c + s;
                    got    = clk_out;
                    e      = pat[len-1-k];
                end
            end
            if (active !== exp_act) act_bad = 1'b1;
            step();
        end
        n_vec++;
        if (bad_at >= 0) begin
            n_bad++;
            $display("FAIL %s wave: half-sample %0d got %0b expected %0b", name, bad_at, got, e);
        end
        n_vec++;
        if (act_bad) begin
            n_bad++;
            $display("FAIL %s active: got %0b expected %0b", name, ~exp_act, exp_act);
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   waited;

        vecs[0] = '{n: 8'd3, half: 1'b1, pat: P_3H, len: 14, name: "n3_half"};
        vecs[1] = '{n: 8'd4, half: 1'b0, pat: P_4,  len: 8,  name: "n4_int"};
        vecs[2] = '{n: 8'd5, half: 1'b0, pat: P_5,  len: 10, name: "n5_int"};
        vecs[3] = '{n: 8'd6, half: 1'b1, pat: P_6H, len: 26, name: "n6_half"};
        vecs[4] = '{n: 8'd2, half: 1'b0, pat: 32'b1100,            len: 4,  name: "n2_int"};
        vecs[5] = '{n: 8'd2, half: 1'b1, pat: 32'b1100011000,      len: 10, name: "n2_half"};
        vecs[6] = '{n: 8'd7, half: 1'b0, pat: 32'b11111110000000,  len: 14, name: "n7_int"};

        rst = 1'b1; en = 1'b0; div_int = '0; div_half = 1'b0; cfg_load = 1'b0;
        #2;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("idle_active", 32'(active), 32'd0);

        // Defaults give /3.5 straight out of reset.
        en = 1'b1;
        step();
        check_wave(P_3H, 14, 0, 14, 1'b1, "default_3p5");

        // N=4 loaded at cnt=2: old 7-cycle pattern completes first.
        check_wave(P_3H, 14, 0, 2, 1'b1, "load4_pre");
        div_int = 8'd4; div_half = 1'b0; cfg_load = 1'b1;
        check_wave(P_3H, 14, 4, 1, 1'b1, "load4_cyc");
        cfg_load = 1'b0;
        check_wave(P_3H, 14, 6, 4, 1'b1, "load4_tail");
        check_wave(P_4, 8, 0, 8, 1'b1, "run_n4");

        // N=5 loaded at cnt=1 of the /4 pattern.
        check_wave(P_4, 8, 0, 1, 1'b1, "load5_pre");
        div_int = 8'd5; cfg_load = 1'b1;
        check_wave(P_4, 8, 2, 1, 1'b1, "load5_cyc");
        cfg_load = 1'b0;
        check_wave(P_4, 8, 4, 2, 1'b1, "load5_tail");
        check_wave(P_5, 10, 0, 10, 1'b1, "run_n5");

        // Illegal loads N=1 then N=0 back-to-back: error pulses, waveform untouched.
        div_int = 8'd1; cfg_load = 1'b1;
        check_wave(P_5, 10, 0, 1, 1'b1, "bad1_cyc");
        chk("cfg_err_n1", 32'(cfg_err), 32'd1);
        div_int = 8'd0;
        check_wave(P_5, 10, 2, 1, 1'b1, "bad0_cyc");
        chk("cfg_err_n0", 32'(cfg_err), 32'd1);
        cfg_load = 1'b0;
        check_wave(P_5, 10, 4, 1, 1'b1, "bad_after");
        chk("cfg_err_clear", 32'(cfg_err), 32'd0);
        check_wave(P_5, 10, 6, 2, 1'b1, "bad_tail");
        check_wave(P_5, 10, 0, 10, 1'b1, "n5_unchanged");

        // N=6 half; en dropped at cnt=2 lets the 13-cycle pattern finish.
        div_int = 8'd6; div_half = 1'b1; cfg_load = 1'b1;
        check_wave(P_5, 10, 0, 1, 1'b1, "load6h_cyc");
        cfg_load = 1'b0;
        check_wave(P_5, 10, 2, 4, 1'b1, "load6h_tail");
        check_wave(P_6H, 26, 0, 2, 1'b1, "n6h_pre_stop");
        en = 1'b0;
        check_wave(P_6H, 26, 4, 11, 1'b1, "n6h_drain");
        check_wave(32'd0, 2, 0, 3, 1'b0, "stopped");
        en = 1'b1;
        step();
        check_wave(P_6H, 26, 0, 13, 1'b1, "n6h_restart");

        // Reset in the middle of pulse B (cnt=7).
        check_wave(P_6H, 26, 0, 7, 1'b1, "n6h_to_b");
        chk("pulse_b_high", 32'(clk_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_clk_out", 32'(clk_out), 32'd0);
        chk("rst_async_active", 32'(active), 32'd0);
        step();
        rst = 1'b0;
        step();
        check_wave(P_3H, 14, 0, 14, 1'b1, "post_rst_3p5");

        // Table: stop, then load-and-start from stopped; the load applies at once.
        foreach (vecs[i]) begin
            en = 1'b0;
            waited = 0;
            while (active === 1'b1 && waited < 600) begin
                step();
                waited++;
            end
            chk({vecs[i].name, "_stop_timeout"}, 32'(waited < 600), 32'd1);
            div_int  = vecs[i].n;
            div_half = vecs[i].half;
            cfg_load = 1'b1;
            en       = 1'b1;
            step();
            cfg_load = 1'b0;
            check_wave(vecs[i].pat, vecs[i].len, 0, vecs[i].len, 1'b1, vecs[i].name);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
